// File: rtl/read_pkg.sv
// Shared declarations for the read_probe snapshot block.
package read_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } read_state_e;

endpackage

// File: rtl/read_pipe.sv
// NumStages-deep delay line with synchronous active-high clear; zero stages is a plain wire.
module read_pipe #(
  parameter type         T         = logic,
  parameter int unsigned NumStages = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     d_i,
  output T     q_o
);

  if (NumStages == 0) begin : g_wire
    assign q_o = d_i;
    // Clock and reset have no load in the wire configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
  end else begin : g_regs
    T stage_q [NumStages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < NumStages; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < NumStages; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[NumStages-1];
  end

endmodule

// File: rtl/read_probe.sv
// Multi-channel keep-alive probe: optional retiming of the probed nets plus a
// triggered snapshot that is drained one channel per valid/ready transfer.
(* no_ungroup *)
module read_probe
  import read_pkg::*;
#(
  parameter int unsigned Width       = 1,
  parameter type         T           = logic [Width-1:0],
  parameter int unsigned NumChannels = 1,
  parameter int unsigned NumStages   = 0,
  parameter int unsigned IdxWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  T [NumChannels-1:0]     d_i,
  output T [NumChannels-1:0]     d_o,
  input  logic                   trig_i,
  input  logic                   clr_i,
  output logic                   busy_o,
  output logic                   snap_valid_o,
  input  logic                   snap_ready_i,
  output T                       snap_data_o,
  output logic [IdxWidth-1:0]    snap_idx_o,
  output logic                   done_o,
  output logic                   ovf_o
);

  typedef T [NumChannels-1:0] chan_vec_t;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChannels - 1);

  read_state_e         state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  chan_vec_t           snap_q;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                capture;
  logic                ovf_set;
  logic                last_xfer;
  T                    snap_word;

  read_pipe #(
    .T         (chan_vec_t),
    .NumStages (NumStages)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (d_i),
    .q_o   (d_o)
  );

  assign last_xfer = (state_q == StDrain) && snap_ready_i && (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    done_d  = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (snap_ready_i) begin
          if (idx_q == LastIdx) begin
            done_d = 1'b1;
            idx_d  = '0;
            // A trigger coinciding with the final transfer re-arms without a bubble.
            if (trig_i) begin
              capture = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxWidth'(1);
          end
        end
        if (trig_i && !last_xfer) begin
          ovf_set = 1'b1;
        end
      end
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      if (capture) begin
        snap_q <= d_o;
      end
    end
  end

  always_comb begin
    snap_word = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (idx_q == IdxWidth'(c)) begin
        snap_word = snap_q[c];
      end
    end
  end

  assign busy_o       = (state_q == StDrain);
  assign snap_valid_o = (state_q == StDrain);
  assign snap_data_o  = snap_word;
  assign snap_idx_o   = idx_q;
  assign done_o       = done_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_read_probe.sv
// Directed bench for read_probe: a 4-channel, 2-stage instance plus a 1-channel wire instance.
module tb_read_probe;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] d_i, d_o;
  logic            trig, clr, ready;
  logic            busy, valid, done, ovf;
  logic [7:0]      snap_data;
  logic [1:0]      snap_idx;

  logic [0:0][7:0] d_i0, d_o0;
  logic            trig0, busy0, valid0, done0, ovf0;
  logic [7:0]      snap_data0;
  logic [0:0]      snap_idx0;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  read_probe #(
    .Width       (8),
    .NumChannels (4),
    .NumStages   (2)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .d_i          (d_i),
    .d_o          (d_o),
    .trig_i       (trig),
    .clr_i        (clr),
    .busy_o       (busy),
    .snap_valid_o (valid),
    .snap_ready_i (ready),
    .snap_data_o  (snap_data),
    .snap_idx_o   (snap_idx),
    .done_o       (done),
    .ovf_o        (ovf)
  );

  read_probe #(
    .Width       (8),
    .NumChannels (1),
    .NumStages   (0)
  ) u_dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .d_i          (d_i0),
    .d_o          (d_o0),
    .trig_i       (trig0),
    .clr_i        (1'b0),
    .busy_o       (busy0),
    .snap_valid_o (valid0),
    .snap_ready_i (1'b1),
    .snap_data_o  (snap_data0),
    .snap_idx_o   (snap_idx0),
    .done_o       (done0),
    .ovf_o        (ovf0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_snap(input logic [3:0][7:0] v);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.data = v[c];
      e.idx  = 2'(c);
      exp_q.push_back(e);
    end
  endtask

  // Compare the presented word against the scoreboard head; pop only if it transfers.
  task automatic word(input logic rdy);
    exp_t e;
    ready = rdy;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed valid=%0b with no expected word", valid);
    end else begin
      e = exp_q[0];
      chk("word_valid", valid, 1);
      chk("word_busy", busy, 1);
      chk("word_data", snap_data, e.data);
      chk("word_idx", snap_idx, e.idx);
      if (rdy) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    d_i   = {4{8'h77}};
    trig  = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    d_i0  = '0;
    trig0 = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_d_o", d_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_idx", snap_idx, 0);
    chk("rst_data", snap_data, 0);
    rst = 1'b0;

    // Passthrough latency
    d_i = '0;
    repeat (2) tick();
    d_i[2] = 8'hA5;
    tick();
    chk("pt_early", d_o[2], 8'h00);
    tick();
    chk("pt_lat2", d_o[2], 8'hA5);
    d_i0 = '{8'h5A};
    #1;
    chk("pt_wire", d_o0, 8'h5A);

    // Single-channel instance: every transfer is the last
    tick();
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    chk("n1_valid", valid0, 1);
    chk("n1_data", snap_data0, 8'h5A);
    chk("n1_idx", snap_idx0, 0);
    tick();
    chk("n1_done", done0, 1);
    chk("n1_idle", busy0, 0);

    // Basic drain
    d_i = {8'h04, 8'h03, 8'h02, 8'h01};
    repeat (2) tick();
    chk("drain_d_o", d_o, 32'h04030201);
    chk("idle_valid", valid, 0);
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_no_done", done, 0);
      word(1'b1);
      tick();
    end
    chk("drain_done", done, 1);
    chk("drain_busy_off", busy, 0);
    chk("drain_valid_off", valid, 0);
    tick();
    chk("drain_done_pulse", done, 0);

    // Backpressure; d_i changes must not disturb the frozen snapshot
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    word(1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      d_i = {4{8'(8'hE0 + i)}};
      word(1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      word(1'b1);
      tick();
    end
    chk("bp_done", done, 1);

    // Overflow: trigger mid-drain is dropped and flagged
    d_i = {8'h24, 8'h23, 8'h22, 8'h21};
    repeat (2) tick();
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    word(1'b1);
    tick();
    word(1'b1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("ovf_set", ovf, 1);
    word(1'b1);
    tick();
    word(1'b1);
    tick();
    chk("ovf_drain_done", done, 1);
    chk("ovf_sticky", ovf, 1);

    // Clear and new overflow together: set wins
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    word(1'b1);
    tick();
    word(1'b0);
    trig = 1'b1;
    clr  = 1'b1;
    tick();
    trig = 1'b0;
    clr  = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    for (int i = 0; i < 3; i++) begin
      word(1'b1);
      tick();
    end
    chk("ovf2_done", done, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Back-to-back: trigger on the final transfer
    d_i = {8'h04, 8'h03, 8'h02, 8'h01};
    repeat (2) tick();
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    d_i = {8'h14, 8'h13, 8'h12, 8'h11};
    for (int i = 0; i < 3; i++) begin
      word(1'b1);
      tick();
    end
    word(1'b1);
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      word(1'b1);
      tick();
    end
    chk("b2b_done2", done, 1);

    // Reset mid-drain
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    word(1'b1);
    tick();
    word(1'b1);
    tick();
    ready = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_idx", snap_idx, 0);
    chk("mrst_data", snap_data, 0);
    chk("mrst_d_o", d_o, 0);
    chk("mrst_done", done, 0);
    tick();
    chk("mrst_no_done", done, 0);
    tick();
    trig = 1'b1;
    push_snap(d_i);
    tick();
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word(1'b1);
      tick();
    end
    chk("mrst_redrain_done", done, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_probe.md
Name: read_probe

Overview:
- Parametrised, multi-channel successor to the single-signal keep-alive buffer.
- Carries NumChannels signals of type T through an optional retiming pipeline. The block is a no-ungroup boundary, so synthesis keeps every probed net.
- On a trigger, freezes a snapshot of all channels and serialises it through a valid/ready port for debug or observation logic.
- Sits between a functional block and a debug or status collector.

Parameters:
- Width, 1, bit width of each channel when T is not overridden.
- T, logic [Width-1:0], channel data type.
- NumChannels, 1, number of probed channels (>=1).
- NumStages, 0, register stages on the passthrough path (0 = pure wire).
- IdxWidth, (NumChannels>1 ? $clog2(NumChannels) : 1), width of the channel index. Derived; never overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- d_i  in  NumChannels x T  probed signals.
- d_o  out  NumChannels x T  d_i delayed by NumStages cycles.
- trig_i  in  1  snapshot request.
- clr_i  in  1  clears the sticky overflow flag.
- busy_o  out  1  snapshot drain in progress.
- snap_valid_o  out  1  snapshot word valid.
- snap_ready_i  in  1  consumer ready.
- snap_data_o  out  T  snapshot word.
- snap_idx_o  out  IdxWidth  channel index of snap_data_o.
- done_o  out  1  one-cycle pulse after the last word transfers.
- ovf_o  out  1  sticky: a trigger was dropped.

Behaviour:
- Module carries the no_ungroup attribute; all state is updated on the rising edge of clk_i only.
- Reset (rst_i high at an edge) has priority over every other input:
  - pipeline registers and snapshot array cleared to '0;
  - FSM goes to IDLE and the index counter to 0;
  - busy_o, snap_valid_o, done_o, ovf_o, snap_idx_o, snap_data_o all 0.
  - Applies mid-drain: the drain is aborted, no done_o pulse, and the snapshot is lost.
- Passthrough:
  - d_o[c](t) = d_i[c](t-NumStages).
  - NumStages=0: combinational, no registers.
  - During reset the pipeline outputs 0.
- Capture:
  - The snapshot samples d_o (pipeline output), all channels in the same edge, when trig_i=1 in IDLE.
  - Snapshot registers never change outside a capture.
- FSM states: IDLE, DRAIN.
  - IDLE -> DRAIN: trig_i=1. Capture occurs and index is set to 0. snap_valid_o=1 from the next cycle (1-cycle latency from trigger).
  - In DRAIN:
    - snap_valid_o=1, busy_o=1;
    - snap_data_o = snapshot[idx], snap_idx_o = idx.
    - Transfer when snap_valid_o && snap_ready_i; idx increments on each transfer.
    - Valid and data stay stable while ready is low.
  - DRAIN -> IDLE: transfer with idx==NumChannels-1. done_o=1 in the following cycle only.
  - Last transfer and trig_i=1 in the same cycle:
    - new capture at that edge, stay in DRAIN with idx=0, no bubble;
    - done_o still pulses;
    - no overflow.
  - trig_i=1 in DRAIN without a last transfer: trigger ignored, ovf_o set at the next edge.
- ovf_o:
  - Sticky until clr_i=1.
  - When clr_i and a new overflow occur in the same cycle, the set wins.
- NumChannels=1: every transfer is the last; snap_idx_o is always 0.
- Index arithmetic is unsigned IdxWidth bits. Wrap-around never occurs because the FSM leaves DRAIN at NumChannels-1.
- In IDLE: snap_valid_o=0 and busy_o=0. snap_data_o shows snapshot[0], snap_idx_o=0.

Decomposition:
- Package read_pkg holds the FSM state enum (IDLE, DRAIN).
- Width- and type-dependent items stay local parameters, since T is a module parameter.
- One sub-module: read_pipe (parametrised T, NumStages delay line with synchronous active-high reset). It is instantiated once per channel, or once with a packed array type.
- Capture, FSM and overflow logic live in read_probe.

Test Plan:
- Passthrough latency:
  - Setup: NumStages=2, NumChannels=4, Width=8; drive d_i[2]=8'hA5 at cycle 10.
  - Expect: d_o[2]=8'hA5 at cycle 12; d_o=0 during reset.
- Basic drain:
  - Setup: d_i={8'h04,8'h03,8'h02,8'h01}, NumStages=0; trig_i pulse; snap_ready_i=1.
  - Expect: words 01,02,03,04 with idx 0..3 on consecutive cycles starting 1 cycle after the trigger; done_o one pulse after idx 3; busy_o low afterwards.
- Backpressure:
  - Setup: hold snap_ready_i=0 for 5 cycles at idx 1.
  - Expect: snap_data_o=02 and idx=1 stable, snap_valid_o held high; change d_i meanwhile and check the snapshot is unaffected.
- Overflow:
  - Setup: trig_i during DRAIN at idx 1.
  - Expect: ovf_o=1 next cycle; drain completes unchanged.
  - Then: clr_i alone clears it; clr_i with a simultaneous new overflow leaves ovf_o=1.
- Back-to-back:
  - Setup: trig_i in the same cycle as the idx-3 transfer, with d_i changed to 8'h1x values.
  - Expect: done_o pulses, the next cycle shows idx 0 with new data, no gap, ovf_o=0.
- Reset mid-drain:
  - Setup: assert rst_i at idx 2.
  - Expect: next cycle all outputs 0, FSM IDLE, no done_o; a subsequent trigger drains from idx 0.
